// File: rtl/xc_malu_issue.sv
`default_nettype none
// xc_malu_issue: issue/writeback sequencer between execute and the multi-cycle MALU.
// Optional random flush fill: define XC_MALU_ISSUE_RNG_FLUSH_EN.
module xc_malu_issue #(
    parameter int MALU_TIMEOUT = 64
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [3:0]  req_op_i,
    input  logic [4:0]  req_pw_i,
    input  logic        req_hi_i,
    input  logic [31:0] req_rs1_i,
    input  logic [31:0] req_rs2_i,
    input  logic [31:0] req_rs3_i,
    input  logic [4:0]  req_rd_i,
    input  logic        kill_i,
    output logic [31:0] malu_rs1_o,
    output logic [31:0] malu_rs2_o,
    output logic [31:0] malu_rs3_o,
    output logic [13:0] malu_uop_o,
    output logic [4:0]  malu_pw_o,
    output logic        malu_valid_o,
    output logic        malu_flush_o,
    output logic [31:0] malu_flush_data_o,
    input  logic [63:0] malu_result_i,
    input  logic        malu_ready_i,
    output logic        wb_valid_o,
    input  logic        wb_ready_i,
    output logic [4:0]  wb_rd_o,
    output logic [31:0] wb_data_o,
    output logic        busy_o,
    output logic        err_o
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RUN   = 3'd1;
    localparam logic [2:0] S_WB_LO = 3'd2;
    localparam logic [2:0] S_WB_HI = 3'd3;
    localparam logic [2:0] S_FLUSH = 3'd4;

    localparam int         CW      = (MALU_TIMEOUT > 2) ? $clog2(MALU_TIMEOUT) : 1;
    localparam logic [CW-1:0] WD_LAST = CW'(MALU_TIMEOUT - 1);

    logic [2:0]    state_q, state_d;
    logic [31:0]   rs1_q, rs1_d, rs2_q, rs2_d, rs3_q, rs3_d;
    logic [3:0]    op_q, op_d;
    logic [4:0]    pw_q, pw_d, rd_q, rd_d;
    logic          hi_q, hi_d, err_q, err_d;
    logic [CW-1:0] wdog_q, wdog_d;
    logic [63:0]   result_q, result_d;
    logic          pair_op;

    // macc and mmul produce a register pair
    assign pair_op = (op_q == 4'd12) || (op_q == 4'd13);

    always_comb begin
        state_d  = state_q;
        rs1_d    = rs1_q;
        rs2_d    = rs2_q;
        rs3_d    = rs3_q;
        op_d     = op_q;
        pw_d     = pw_q;
        rd_d     = rd_q;
        hi_d     = hi_q;
        wdog_d   = wdog_q;
        result_d = result_q;
        err_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_valid_i && !kill_i) begin
                    if (req_op_i >= 4'd14) begin
                        err_d = 1'b1;
                    end else begin
                        rs1_d   = req_rs1_i;
                        rs2_d   = req_rs2_i;
                        rs3_d   = req_rs3_i;
                        op_d    = req_op_i;
                        pw_d    = req_pw_i;
                        rd_d    = req_rd_i;
                        hi_d    = req_hi_i;
                        wdog_d  = '0;
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                wdog_d = wdog_q + 1'b1;
                if (kill_i) begin
                    state_d = S_FLUSH;
                end else if (malu_ready_i) begin
                    result_d = malu_result_i;
                    state_d  = S_WB_LO;
                end else if (wdog_q == WD_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_FLUSH;
                end
            end
            S_WB_LO: begin
                if (kill_i) begin
                    state_d = S_FLUSH;
                end else if (wb_ready_i) begin
                    state_d = pair_op ? S_WB_HI : S_FLUSH;
                end
            end
            S_WB_HI: begin
                if (kill_i || wb_ready_i) begin
                    state_d = S_FLUSH;
                end
            end
            S_FLUSH: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            rs1_q    <= '0;
            rs2_q    <= '0;
            rs3_q    <= '0;
            op_q     <= '0;
            pw_q     <= '0;
            rd_q     <= '0;
            hi_q     <= 1'b0;
            wdog_q   <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rs1_q    <= rs1_d;
            rs2_q    <= rs2_d;
            rs3_q    <= rs3_d;
            op_q     <= op_d;
            pw_q     <= pw_d;
            rd_q     <= rd_d;
            hi_q     <= hi_d;
            wdog_q   <= wdog_d;
            result_q <= result_d;
            err_q    <= err_d;
        end
    end

    assign req_ready_o  = (state_q == S_IDLE) && !kill_i;
    assign busy_o       = (state_q != S_IDLE);
    assign err_o        = err_q;
    assign malu_valid_o = (state_q == S_RUN);
    assign malu_flush_o = (state_q == S_FLUSH);
    assign malu_uop_o   = (state_q == S_RUN) ? (14'd1 << op_q) : 14'd0;
    assign malu_pw_o    = pw_q;
    assign malu_rs1_o   = rs1_q;
    assign malu_rs2_o   = rs2_q;
    assign malu_rs3_o   = rs3_q;

    always_comb begin
        wb_valid_o = 1'b0;
        wb_rd_o    = 5'd0;
        wb_data_o  = 32'd0;
        if (state_q == S_WB_LO) begin
            wb_valid_o = 1'b1;
            wb_rd_o    = pair_op ? {rd_q[4:1], 1'b0} : rd_q;
            wb_data_o  = (!pair_op && hi_q) ? result_q[63:32] : result_q[31:0];
        end else if (state_q == S_WB_HI) begin
            wb_valid_o = 1'b1;
            wb_rd_o    = {rd_q[4:1], 1'b1};
            wb_data_o  = result_q[63:32];
        end
    end

`ifdef XC_MALU_ISSUE_RNG_FLUSH_EN
    // Galois LFSR, x^32 + x^22 + x^2 + x + 1; free-running once out of reset
    logic [31:0] lfsr_q, lfsr_d;

    assign lfsr_d = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? 32'h8020_0003 : 32'h0);

    always_ff @(posedge clock) begin
        if (!resetn) begin
            lfsr_q <= 32'hACE1_2468;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign malu_flush_data_o = lfsr_q;
`else
    assign malu_flush_data_o = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_xc_malu_issue.sv
`default_nettype none
// tb_xc_malu_issue: table vectors, hand-written corner sequences and random traffic
// against a writeback-list reference model.
module tb_xc_malu_issue;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic [3:0]  req_op_i = '0;
    logic [4:0]  req_pw_i = '0;
    logic        req_hi_i = 1'b0;
    logic [31:0] req_rs1_i = '0, req_rs2_i = '0, req_rs3_i = '0;
    logic [4:0]  req_rd_i = '0;
    logic        kill_i = 1'b0;
    logic [31:0] malu_rs1_o, malu_rs2_o, malu_rs3_o;
    logic [13:0] malu_uop_o;
    logic [4:0]  malu_pw_o;
    logic        malu_valid_o, malu_flush_o;
    logic [31:0] malu_flush_data_o;
    logic [63:0] malu_result_i = '0;
    logic        malu_ready_i = 1'b0;
    logic        wb_valid_o;
    logic        wb_ready_i = 1'b0;
    logic [4:0]  wb_rd_o;
    logic [31:0] wb_data_o;
    logic        busy_o, err_o;

    xc_malu_issue #(.MALU_TIMEOUT(64)) dut (
        .clock(clock), .resetn(resetn),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_op_i(req_op_i),
        .req_pw_i(req_pw_i), .req_hi_i(req_hi_i), .req_rs1_i(req_rs1_i),
        .req_rs2_i(req_rs2_i), .req_rs3_i(req_rs3_i), .req_rd_i(req_rd_i),
        .kill_i(kill_i), .malu_rs1_o(malu_rs1_o), .malu_rs2_o(malu_rs2_o),
        .malu_rs3_o(malu_rs3_o), .malu_uop_o(malu_uop_o), .malu_pw_o(malu_pw_o),
        .malu_valid_o(malu_valid_o), .malu_flush_o(malu_flush_o),
        .malu_flush_data_o(malu_flush_data_o), .malu_result_i(malu_result_i),
        .malu_ready_i(malu_ready_i), .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i),
        .wb_rd_o(wb_rd_o), .wb_data_o(wb_data_o), .busy_o(busy_o), .err_o(err_o)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [3:0]  op;
        logic        hi;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] exp_data;
        logic [4:0]  exp_rd;
    } vec_t;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] d;
    } wb_t;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] last_fd;
    logic        have_fd = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Arithmetic stand-in for the MALU; ops without a simple closed form get a random result
    function automatic logic [63:0] malu_calc(input logic [3:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        logic [31:0] q;
        case (op)
            4'd0: begin q = 32'($signed(a) / $signed(b)); return {32'h0, q}; end
            4'd1: return {32'h0, a / b};
            4'd2: begin q = 32'($signed(a) % $signed(b)); return {32'h0, q}; end
            4'd3: return {32'h0, a % b};
            4'd4: return {{32{a[31]}}, a} * {{32{b[31]}}, b};
            4'd5: return {32'h0, a} * {32'h0, b};
            4'd6: return {{32{a[31]}}, a} * {32'h0, b};
            default: return {$urandom, $urandom};
        endcase
    endfunction

    task automatic flush_data_check();
`ifdef XC_MALU_ISSUE_RNG_FLUSH_EN
        check("flush_data_nonzero", malu_flush_data_o != 32'd0, 1);
        if (have_fd) check("flush_data_varies", malu_flush_data_o != last_fd, 1);
`else
        check("flush_data_zero", malu_flush_data_o, 0);
`endif
        last_fd = malu_flush_data_o;
        have_fd = 1'b1;
    endtask

    task automatic do_txn(input logic [3:0] op, input logic hi, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] c, input logic [4:0] rd,
                          input logic [4:0] pw, input logic [63:0] res, input int lat,
                          input int stall, output logic [31:0] first_data,
                          output logic [4:0] first_rd);
        wb_t exp_q[$];
        if (op == 4'd12 || op == 4'd13) begin
            exp_q.push_back('{rd & 5'h1e, res[31:0]});
            exp_q.push_back('{rd | 5'h01, res[63:32]});
        end else begin
            exp_q.push_back('{rd, hi ? res[63:32] : res[31:0]});
        end
        first_data = '0;
        first_rd   = '0;
        req_valid_i = 1'b1; req_op_i = op; req_hi_i = hi; req_rs1_i = a;
        req_rs2_i = b; req_rs3_i = c; req_rd_i = rd; req_pw_i = pw;
        #1;
        check("req_ready_idle", req_ready_o, 1);
        check("busy_idle", busy_o, 0);
        tick();
        req_valid_i = 1'b0;
        req_rs1_i = $urandom;
        for (int i = 0; i < lat; i++) begin
            check("malu_valid", malu_valid_o, 1);
            check("malu_uop", malu_uop_o, 64'd1 << op);
            check("malu_rs1", malu_rs1_o, a);
            check("malu_rs2", malu_rs2_o, b);
            check("malu_rs3", malu_rs3_o, c);
            check("malu_pw", malu_pw_o, pw);
            check("wb_valid_run", wb_valid_o, 0);
            malu_ready_i  = (i == lat - 1);
            malu_result_i = (i == lat - 1) ? res : {$urandom, $urandom};
            tick();
        end
        malu_ready_i  = 1'b0;
        malu_result_i = {$urandom, $urandom};
        check("err_after_run", err_o, 0);
        foreach (exp_q[k]) begin
            for (int s = 0; s < stall; s++) begin
                wb_ready_i = 1'b0;
                check("wb_valid_stall", wb_valid_o, 1);
                check("wb_rd_stall", wb_rd_o, exp_q[k].rd);
                check("wb_data_stall", wb_data_o, exp_q[k].d);
                tick();
                malu_result_i = {$urandom, $urandom};
            end
            wb_ready_i = 1'b1;
            check("wb_valid", wb_valid_o, 1);
            check("wb_rd", wb_rd_o, exp_q[k].rd);
            check("wb_data", wb_data_o, exp_q[k].d);
            check("malu_valid_wb", malu_valid_o, 0);
            if (k == 0) begin
                first_data = wb_data_o;
                first_rd   = wb_rd_o;
            end
            tick();
            wb_ready_i = 1'b0;
        end
        check("flush_on", malu_flush_o, 1);
        check("wb_valid_flush", wb_valid_o, 0);
        check("malu_uop_flush", malu_uop_o, 0);
        flush_data_check();
        tick();
        check("flush_off", malu_flush_o, 0);
        check("busy_done", busy_o, 0);
    endtask

    vec_t        tbl[8];
    logic [31:0] fd;
    logic [4:0]  frd;
    int          n;

    initial begin
        tbl[0] = '{4'd1, 1'b0, 32'd100,       32'd7, 5'd3,  32'd14,         5'd3};
        tbl[1] = '{4'd3, 1'b0, 32'd100,       32'd7, 5'd3,  32'd2,          5'd3};
        tbl[2] = '{4'd5, 1'b1, 32'hFFFF_FFFF, 32'd2, 5'd10, 32'h0000_0001,  5'd10};
        tbl[3] = '{4'd5, 1'b0, 32'hFFFF_FFFF, 32'd2, 5'd10, 32'hFFFF_FFFE,  5'd10};
        tbl[4] = '{4'd0, 1'b0, 32'hFFFF_FF9C, 32'd7, 5'd17, 32'hFFFF_FFF2,  5'd17};
        tbl[5] = '{4'd2, 1'b0, 32'hFFFF_FF9C, 32'd7, 5'd17, 32'hFFFF_FFFE,  5'd17};
        tbl[6] = '{4'd4, 1'b0, 32'hFFFF_FFFD, 32'd5, 5'd1,  32'hFFFF_FFF1,  5'd1};
        tbl[7] = '{4'd6, 1'b1, 32'hFFFF_FFFF, 32'd2, 5'd30, 32'hFFFF_FFFF,  5'd30};

        repeat (3) tick();
        check("rst_busy", busy_o, 0);
        check("rst_malu_valid", malu_valid_o, 0);
        check("rst_flush", malu_flush_o, 0);
        check("rst_wb_valid", wb_valid_o, 0);
        check("rst_err", err_o, 0);
        check("rst_uop", malu_uop_o, 0);
`ifdef XC_MALU_ISSUE_RNG_FLUSH_EN
        check("rst_lfsr_seed", malu_flush_data_o, 32'hACE1_2468);
`else
        check("rst_flush_data", malu_flush_data_o, 0);
`endif
        resetn = 1'b1;
        tick();

        kill_i = 1'b1;
        #1;
        check("req_ready_killed", req_ready_o, 0);
        kill_i = 1'b0;
        tick();

        foreach (tbl[i]) begin
            do_txn(tbl[i].op, tbl[i].hi, tbl[i].a, tbl[i].b, 32'h0, tbl[i].rd, 5'b10000,
                   malu_calc(tbl[i].op, tbl[i].a, tbl[i].b), 1, 0, fd, frd);
            check("tbl_data", fd, tbl[i].exp_data);
            check("tbl_rd", frd, tbl[i].exp_rd);
        end

        // Register pair with a stalled writeback
        do_txn(4'd13, 1'b0, 32'h1, 32'h2, 32'h3, 5'd7, 5'b00100, 64'h1122_3344_5566_7788,
               2, 3, fd, frd);
        check("mmul_lo_data", fd, 32'h5566_7788);
        check("mmul_lo_rd", frd, 5'd6);

        // malu_ready on the last watchdog cycle still wins
        do_txn(4'd4, 1'b1, 32'h7, 32'h9, 32'h0, 5'd4, 5'b00001, 64'hDEAD_BEEF_0000_0001,
               64, 0, fd, frd);

        // kill in the 3rd RUN cycle
        req_valid_i = 1'b1; req_op_i = 4'd0; req_rs1_i = 32'd50; req_rs2_i = 32'd5;
        req_rd_i = 5'd9; req_hi_i = 1'b0;
        tick();
        req_valid_i = 1'b0;
        tick();
        tick();
        check("kill_still_run", malu_valid_o, 1);
        kill_i = 1'b1;
        tick();
        kill_i = 1'b0;
        check("kill_flush", malu_flush_o, 1);
        check("kill_no_wb", wb_valid_o, 0);
        check("kill_no_err", err_o, 0);
        flush_data_check();
        tick();
        check("kill_idle", busy_o, 0);
        check("kill_err_after", err_o, 0);
        do_txn(4'd1, 1'b0, 32'd81, 32'd9, 32'h0, 5'd2, 5'b10000, 64'd9, 1, 1, fd, frd);

        // kill alongside the first half of a pair writeback
        req_valid_i = 1'b1; req_op_i = 4'd12; req_rd_i = 5'd21;
        tick();
        req_valid_i = 1'b0;
        malu_ready_i = 1'b1; malu_result_i = 64'hAAAA_BBBB_CCCC_DDDD;
        tick();
        malu_ready_i = 1'b0;
        wb_ready_i = 1'b1; kill_i = 1'b1;
        check("killwb_valid", wb_valid_o, 1);
        check("killwb_rd", wb_rd_o, 5'd20);
        check("killwb_data", wb_data_o, 32'hCCCC_DDDD);
        tick();
        wb_ready_i = 1'b0; kill_i = 1'b0;
        check("killwb_flush", malu_flush_o, 1);
        check("killwb_no_hi", wb_valid_o, 0);
        flush_data_check();
        tick();
        check("killwb_idle", busy_o, 0);

        // illegal op
        req_valid_i = 1'b1; req_op_i = 4'd15;
        #1;
        check("illegal_ready", req_ready_o, 1);
        tick();
        req_valid_i = 1'b0;
        check("illegal_err", err_o, 1);
        check("illegal_busy", busy_o, 0);
        check("illegal_no_malu", malu_valid_o, 0);
        check("illegal_no_wb", wb_valid_o, 0);
        tick();
        check("illegal_err_pulse", err_o, 0);
        check("illegal_no_malu2", malu_valid_o, 0);

        // watchdog
        req_valid_i = 1'b1; req_op_i = 4'd5;
        tick();
        req_valid_i = 1'b0;
        n = 0;
        while (malu_valid_o && n < 200) begin
            n++;
            tick();
        end
        check("wdog_run_cycles", n, 64);
        check("wdog_err", err_o, 1);
        check("wdog_flush", malu_flush_o, 1);
        check("wdog_no_wb", wb_valid_o, 0);
        flush_data_check();
        tick();
        check("wdog_err_pulse", err_o, 0);
        check("wdog_idle", busy_o, 0);

        // reset during RUN
        req_valid_i = 1'b1; req_op_i = 4'd4; req_rs1_i = 32'h1234;
        tick();
        req_valid_i = 1'b0;
        resetn = 1'b0;
        tick();
        check("midrst_busy", busy_o, 0);
        check("midrst_valid", malu_valid_o, 0);
        check("midrst_rs1", malu_rs1_o, 0);
        check("midrst_wb", wb_valid_o, 0);
        resetn = 1'b1;
        tick();

        for (int r = 0; r < 30; r++) begin
            logic [3:0]  op;
            logic [31:0] a, b;
            op = 4'($urandom_range(0, 13));
            a  = $urandom;
            b  = (op <= 4'd3) ? 32'($urandom_range(1, 1000)) : $urandom;
            do_txn(op, 1'($urandom), a, b, $urandom, 5'($urandom), 5'd1 << $urandom_range(0, 4),
                   malu_calc(op, a, b), $urandom_range(1, 6), $urandom_range(0, 2), fd, frd);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
